// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand-issue stage.
// Holds the ALU funct encodings, RV32I opcodes, the EX slot layout and the instruction decoder.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RIDX_W = $clog2(NREGS);

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h8;
    localparam logic [3:0] ALU_SLL  = 4'h1;
    localparam logic [3:0] ALU_SLT  = 4'h2;
    localparam logic [3:0] ALU_SLTU = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SRL  = 4'h5;
    localparam logic [3:0] ALU_SRA  = 4'hD;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_AND  = 4'h7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic              valid;
        logic              illegal;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [3:0]        funct;
    } ex_slot_t;

    typedef struct packed {
        logic            illegal;
        logic            use_rs1;
        logic            use_rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      funct;
    } dec_t;

    // Operand selection only; register values are resolved by the caller.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = instr[14:12];
        f7 = instr[31:25];
        d = '0;
        d.illegal = 1'b1;
        case (instr[6:0])
            OPC_OP: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.funct   = {instr[30], f3};
                d.illegal = !((f7 == F7_ZERO) ||
                              ((f7 == F7_ALT) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OPC_OP_IMM: begin
                d.use_rs1 = 1'b1;
                d.imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
                d.funct   = {(f3 == 3'd5) & instr[30], f3};
                if (f3 == 3'd1) begin
                    d.illegal = (f7 != F7_ZERO);
                end else if (f3 == 3'd5) begin
                    d.illegal = !((f7 == F7_ZERO) || (f7 == F7_ALT));
                end else begin
                    d.illegal = 1'b0;
                end
            end
            OPC_LUI: begin
                d.imm     = {instr[31:12], 12'b0};
                d.funct   = ALU_ADD;
                d.illegal = 1'b0;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous write port.
// Entry 0 is hardwired to zero on both the write and read sides.
module reg_file #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rd_addr_a,
    output logic [XLEN-1:0] rd_data_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [XLEN-1:0] rd_data_b,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue and writeback stage: decodes OP/OP-IMM/LUI, latches ALU operands into a
// single EX slot, and writes the ALU result back to rd when the slot retires.
module alu_issue
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_funct,
    input  logic [XLEN-1:0] alu_o,
    output logic            ret_valid,
    input  logic            ret_ready,
    output logic [4:0]      ret_rd,
    output logic [XLEN-1:0] ret_data,
    output logic            ret_illegal
);

    ex_slot_t          ex_q;
    ex_slot_t          ex_d;
    dec_t              dec;
    logic              accept;
    logic              retire;
    logic              wr_en;
    logic [RIDX_W-1:0] rs1_idx;
    logic [RIDX_W-1:0] rs2_idx;
    logic [XLEN-1:0]   rf_rs1;
    logic [XLEN-1:0]   rf_rs2;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid may not depend on ready, and a stalled EX slot holds every output stable.
    assign retire   = ex_q.valid & ret_ready;
    assign in_ready = ~ex_q.valid | ret_ready;
    assign accept   = in_valid & in_ready;
    assign wr_en    = retire & ~ex_q.illegal & (ex_q.rd != '0);

    assign rs1_idx = in_instr[19:15];
    assign rs2_idx = in_instr[24:20];

    reg_file #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rs1_idx),
        .rd_data_a (rf_rs1),
        .rd_addr_b (rs2_idx),
        .rd_data_b (rf_rs2),
        .wr_en     (wr_en),
        .wr_addr   (ex_q.rd),
        .wr_data   (alu_o)
    );

    // The retiring result is written at the same edge the new operands are latched,
    // so a reader of that register must take alu_o directly.
    always_comb begin
        dec     = decode(in_instr);
        rs1_val = (wr_en && (rs1_idx == ex_q.rd)) ? alu_o : rf_rs1;
        rs2_val = (wr_en && (rs2_idx == ex_q.rd)) ? alu_o : rf_rs2;
    end

    always_comb begin
        ex_d = ex_q;
        if (accept) begin
            ex_d.valid   = 1'b1;
            ex_d.illegal = dec.illegal;
            ex_d.rd      = in_instr[11:7];
            if (dec.illegal) begin
                ex_d.a     = '0;
                ex_d.b     = '0;
                ex_d.funct = '0;
            end else begin
                ex_d.a     = dec.use_rs1 ? rs1_val : '0;
                ex_d.b     = dec.use_rs2 ? rs2_val : dec.imm;
                ex_d.funct = dec.funct;
            end
        end else if (retire) begin
            ex_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign alu_a       = ex_q.a;
    assign alu_b       = ex_q.b;
    assign alu_funct   = ex_q.funct;
    assign ret_valid   = ex_q.valid;
    assign ret_rd      = ex_q.rd;
    assign ret_illegal = ex_q.illegal;
    assign ret_data    = alu_o;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue with a behavioural ALU attached; an instruction-level model of the
// RV32I subset predicts each retirement into a queue that a negedge monitor drains.
module tb_alu_issue;

    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_OP_IMM = 7'b0010011;
    localparam logic [6:0] T_LUI    = 7'b0110111;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_funct;
    logic [31:0] alu_o;
    logic        ret_valid;
    logic        ret_ready;
    logic [4:0]  ret_rd;
    logic [31:0] ret_data;
    logic        ret_illegal;

    logic        rand_rdy;
    logic        rdy_force;
    logic        rnd_rdy;

    int          checks;
    int          errors;
    int          retires;
    int          stall_cycles;

    logic [37:0] exp_q[$];
    logic [31:0] model_rf[32];

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_funct   (alu_funct),
        .alu_o       (alu_o),
        .ret_valid   (ret_valid),
        .ret_ready   (ret_ready),
        .ret_rd      (ret_rd),
        .ret_data    (ret_data),
        .ret_illegal (ret_illegal)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural ALU ----------------
    always_comb begin
        alu_o = '0;
        case (alu_funct)
            4'h0: alu_o = alu_a + alu_b;
            4'h8: alu_o = alu_a - alu_b;
            4'h1: alu_o = alu_a << alu_b[4:0];
            4'h2: alu_o = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'h3: alu_o = {31'b0, alu_a < alu_b};
            4'h4: alu_o = alu_a ^ alu_b;
            4'h5: alu_o = alu_a >> alu_b[4:0];
            4'hD: alu_o = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'h6: alu_o = alu_a | alu_b;
            4'h7: alu_o = alu_a & alu_b;
            default: alu_o = '0;
        endcase
    end

    assign ret_ready = rand_rdy ? rnd_rdy : rdy_force;

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget exhausted, expected completion", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] op_result(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (f3)
            3'd0: r = alt ? x - y : x + y;
            3'd1: r = x << y[4:0];
            3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: r = (x < y) ? 32'd1 : 32'd0;
            3'd4: r = x ^ y;
            3'd5: r = alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6: r = x | y;
            default: r = x & y;
        endcase
        return r;
    endfunction

    function automatic void ref_exec(input logic [31:0] ins);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] imm;
        logic [31:0] res;
        logic        ill;
        f7  = ins[31:25];
        f3  = ins[14:12];
        rd  = ins[11:7];
        x   = model_rf[ins[19:15]];
        y   = model_rf[ins[24:20]];
        imm = {{20{ins[31]}}, ins[31:20]};
        res = '0;
        ill = 1'b1;
        if (ins[6:0] == T_OP) begin
            ill = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
            res = op_result(f3, f7 == 7'h20, x, y);
        end else if (ins[6:0] == T_OP_IMM) begin
            ill = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                  ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
            res = op_result(f3, (f3 == 3'd5) && (f7 == 7'h20), x, imm);
        end else if (ins[6:0] == T_LUI) begin
            ill = 1'b0;
            res = {ins[31:12], 12'h000};
        end
        if (!ill && rd != 5'd0) model_rf[rd] = res;
        exp_q.push_back({ill, rd, res});
    endfunction

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, T_OP};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, T_LUI};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [6:0]  bad_opc[5];
        int          k;
        bad_opc[0] = 7'b0000011;
        bad_opc[1] = 7'b0100011;
        bad_opc[2] = 7'b1100011;
        bad_opc[3] = 7'b1101111;
        bad_opc[4] = 7'b0010111;
        r   = $urandom;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = r[2:0];
        f7  = r[9:3];
        imm = r[31:20];
        k   = int'($urandom_range(0, 9));
        if (k <= 3) begin
            if (!((f3 == 3'd0 || f3 == 3'd5) && r[10])) f7 = 7'h00;
            else f7 = 7'h20;
            return enc_r(f7, rs2, rs1, f3, rd);
        end else if (k <= 6) begin
            if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = (f3 == 3'd5 && r[10]) ? 7'h20 : 7'h00;
            return enc_i(imm, rs1, f3, rd, T_OP_IMM);
        end else if (k == 7) begin
            return enc_u(r[31:12], rd);
        end else if (k == 8) begin
            return {r[31:12], rd, bad_opc[$urandom_range(0, 4)]};
        end
        return (r[11]) ? enc_r(f7, rs2, rs1, f3, rd) : enc_i({f7, rs2}, rs1, f3, rd, T_OP_IMM);
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] ins);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) note_fail("issue_accept");
        else ref_exec(ins);
        stall_cycles += n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ret_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0 || ret_valid) note_fail(name);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [37:0] e;
        if (rst_n && ret_valid && ret_ready) begin
            retires++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: rd=%0d with no pending expectation", ret_rd);
            end else begin
                e = exp_q.pop_front();
                chk("ret_rd", 32'(ret_rd), 32'(e[36:32]));
                chk("ret_illegal", 32'(ret_illegal), 32'(e[37]));
                if (e[37]) begin
                    chk("illegal_ops", {alu_a | alu_b, 28'(0)} | 32'(alu_funct), 32'd0);
                end else begin
                    chk("ret_data", ret_data, e[31:0]);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    logic [31:0] snap_a;
    logic [31:0] snap_b;
    logic [3:0]  snap_f;
    int          r0;

    initial begin
        checks       = 0;
        errors       = 0;
        retires      = 0;
        stall_cycles = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_instr     = '0;
        rand_rdy     = 1'b0;
        rdy_force    = 1'b1;
        rnd_rdy      = 1'b0;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ret_valid", 32'(ret_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_funct", 32'(alu_funct), 32'd0);
        chk("rst_ret_rd", 32'(ret_rd), 32'd0);
        chk("rst_ret_illegal", 32'(ret_illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed burst, back-to-back with retire always ready.
        stall_cycles = 0;
        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1, T_OP_IMM));
        chk("latency_one_cycle", 32'(ret_valid), 32'd1);
        issue(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, T_OP_IMM));
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
        issue(enc_i({7'h20, 5'd1}, 5'd2, 3'd5, 5'd5, T_OP_IMM));
        issue(enc_i({7'h00, 5'd28}, 5'd2, 3'd5, 5'd6, T_OP_IMM));
        issue(enc_u(20'h12345, 5'd7));
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0, T_OP_IMM));
        issue(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8));
        issue(enc_i(12'd0, 5'd1, 3'd2, 5'd9, 7'b0000011));
        issue(enc_i({7'h20, 5'd3}, 5'd1, 3'd1, 5'd11, T_OP_IMM));
        issue(enc_r(7'h00, 5'd11, 5'd9, 3'd6, 5'd12));
        chk("burst_no_stall", 32'(stall_cycles), 32'd0);
        wait_drain("drain_directed");

        // Back-pressure: EX full, retire held off for three cycles.
        rdy_force = 1'b0;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd9));
        snap_a   = alu_a;
        snap_b   = alu_b;
        snap_f   = alu_funct;
        in_valid = 1'b1;
        in_instr = enc_i(12'd1, 5'd9, 3'd0, 5'd10, T_OP_IMM);
        r0       = retires;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_ret_valid", 32'(ret_valid), 32'd1);
            chk("stall_operands", (alu_a ^ snap_a) | (alu_b ^ snap_b) | 32'(alu_funct ^ snap_f), 32'd0);
        end
        chk("stall_no_retire", 32'(retires - r0), 32'd0);
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        ref_exec(in_instr);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("release_single_retire", 32'(retires - r0), 32'd1);
        wait_drain("drain_stall");

        // Randomized traffic with random retire back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            issue(rand_instr());
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        wait_drain("drain_random");

        // Reset with EX full and retire blocked.
        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1, T_OP_IMM));
        issue(enc_i(12'd9, 5'd0, 3'd0, 5'd3, T_OP_IMM));
        wait_drain("drain_prereset");
        rdy_force = 1'b0;
        issue(enc_i(12'd99, 5'd0, 3'd0, 5'd10, T_OP_IMM));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_kills_ex", 32'(ret_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_alu_a", alu_a, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_n     = 1'b1;
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k < 32; k++) begin
            issue(enc_r(7'h00, 5'd0, 5'(k), 3'd6, 5'(k)));
        end
        wait_drain("drain_final");
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
